// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with single-line refill from a 128-bit memory port.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_EN.
module icache_dm #(
    parameter int unsigned IDX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int unsigned NUM_LINES = 1 << IDX_W;
    localparam int unsigned TAG_W     = 28 - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [127:0]           data_q [NUM_LINES];

    logic [IDX_W-1:0]       addr_idx;
    logic [TAG_W-1:0]       addr_tag;
    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic [127:0]           line_sel;
    logic                   hit;
    logic                   miss_start;
    logic                   fill_done;

    assign addr_idx   = proc_addr[IDX_W+1:2];
    assign addr_tag   = proc_addr[29:IDX_W+2];
    assign fill_idx   = mem_addr[IDX_W-1:0];
    assign fill_tag   = mem_addr[27:IDX_W];
    assign line_sel   = data_q[addr_idx];

    assign hit        = proc_read & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    assign proc_stall = proc_read & ~((state_q == IDLE) & hit);
    assign proc_rdata = line_sel[{proc_addr[1:0], 5'd0} +: 32];
    assign miss_start = (state_q == IDLE) & proc_read & ~hit;
    assign fill_done  = (state_q == REFILL) & mem_ready;

    assign mem_write  = 1'b0;
    assign mem_wdata  = 128'd0;

    // Write data and the store-side interface are intentionally ignored by a read-only cache.
    logic unused_ok;
    assign unused_ok = ^{proc_write, proc_wdata};

    // Control FSM: latches the missing line address and holds the refill request until mem_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mem_read <= 1'b0;
            mem_addr <= 28'd0;
            valid_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        mem_addr <= proc_addr[29:2];
                        mem_read <= 1'b1;
                        state_q  <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_read          <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

    // Line storage; a refill coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if ((state_q == IDLE) && hit) hit_cnt <= hit_cnt + 32'd1;
            if (miss_start)               miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
